// File: rtl/fxu_rs_pkg.sv
// fxu_rs_pkg: shared widths, opcodes and entry-state encoding for the
// fixed-point reservation station.
package fxu_rs_pkg;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_JEQ = 4'd6;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READY  = 2'd2,
    ST_ISSUED = 2'd3
  } ent_state_t;
endpackage

// File: rtl/fxu_rs_entry.sv
// fxu_rs_entry: one reservation-station slot. Holds op and two operands,
// captures pending operands from the CDB, and frees itself when the FXU
// result carrying its own tag is broadcast.
//   alloc      : dispatch is written into this slot (slot must be FREE)
//   issue      : slot is selected for issue this cycle (slot is READY)
//   disp_*     : dispatched op / operand presence / tags / values
//   cdb_*      : common data bus snoop
//   is_free    : slot FREE (pre-clock state)
//   is_ready   : slot READY (pre-clock state)
//   op/val0/val1 : stored payload presented to the issue mux
module fxu_rs_entry
  import fxu_rs_pkg::*;
#(
  parameter logic [TAG_W-1:0] TAG = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              issue,
  input  logic [OP_W-1:0]   disp_op,
  input  logic              disp_rdy0,
  input  logic [TAG_W-1:0]  disp_tag0,
  input  logic [DATA_W-1:0] disp_val0,
  input  logic              disp_rdy1,
  input  logic [TAG_W-1:0]  disp_tag1,
  input  logic [DATA_W-1:0] disp_val1,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              is_free,
  output logic              is_ready,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] val0,
  output logic [DATA_W-1:0] val1
);
  ent_state_t       st;
  logic             rdy0, rdy1;
  logic [TAG_W-1:0] tag0, tag1;

  // Stored-operand hits, dispatch-bypass hits, and own-tag broadcast.
  logic hit0, hit1, dhit0, dhit1, own_hit;
  assign hit0    = cdb_valid && (cdb_tag == tag0);
  assign hit1    = cdb_valid && (cdb_tag == tag1);
  assign dhit0   = cdb_valid && (cdb_tag == disp_tag0);
  assign dhit1   = cdb_valid && (cdb_tag == disp_tag1);
  assign own_hit = cdb_valid && (cdb_tag == TAG);

  assign is_free  = (st == ST_FREE);
  assign is_ready = (st == ST_READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= ST_FREE;
      rdy0 <= 1'b0;
      rdy1 <= 1'b0;
      tag0 <= '0;
      tag1 <= '0;
      op   <= '0;
      val0 <= '0;
      val1 <= '0;
    end else begin
      case (st)
        ST_FREE: if (alloc) begin
          op   <= disp_op;
          tag0 <= disp_tag0;
          tag1 <= disp_tag1;
          rdy0 <= disp_rdy0 || dhit0;
          rdy1 <= disp_rdy1 || dhit1;
          // A pending operand not bypassed latches don't-care data; it is
          // overwritten on capture.
          val0 <= disp_rdy0 ? disp_val0 : cdb_data;
          val1 <= disp_rdy1 ? disp_val1 : cdb_data;
          st   <= ((disp_rdy0 || dhit0) && (disp_rdy1 || dhit1)) ? ST_READY : ST_WAIT;
        end
        ST_WAIT: begin
          if (!rdy0 && hit0) begin
            rdy0 <= 1'b1;
            val0 <= cdb_data;
          end
          if (!rdy1 && hit1) begin
            rdy1 <= 1'b1;
            val1 <= cdb_data;
          end
          if ((rdy0 || hit0) && (rdy1 || hit1)) st <= ST_READY;
        end
        ST_READY:  if (issue)   st <= ST_ISSUED;
        ST_ISSUED: if (own_hit) st <= ST_FREE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Own tag on the CDB before issue means a tag was aliased upstream.
  always_ff @(posedge clk) begin
    if (!reset && own_hit && (st == ST_WAIT || st == ST_READY)) begin
      $display("fxu_rs_entry: tag %0d broadcast while entry not issued", TAG);
      $finish;
    end
  end
`endif
endmodule

// File: rtl/fxu_rs.sv
// fxu_rs: reservation-station bank in front of the fixed-point unit.
// Allocates the lowest FREE entry on dispatch, snoops the CDB through each
// entry, and issues the lowest READY entry to the FXU at most every other
// cycle.
//   disp_*   : dispatch request; disp_tag/full report allocation (comb)
//   cdb_*    : common data bus broadcast
//   fxu_*    : registered issue strobe and payload; fxu_busy from the FXU
module fxu_rs
  import fxu_rs_pkg::*;
#(
  parameter int               NUM_ENTRIES = 4,
  parameter logic [TAG_W-1:0] BASE_TAG    = 6'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic              disp_rdy0,
  input  logic [TAG_W-1:0]  disp_tag0,
  input  logic [DATA_W-1:0] disp_val0,
  input  logic              disp_rdy1,
  input  logic [TAG_W-1:0]  disp_tag1,
  input  logic [DATA_W-1:0] disp_val1,
  output logic [TAG_W-1:0]  disp_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              fxu_valid,
  output logic [TAG_W-1:0]  fxu_rs_num,
  output logic [OP_W-1:0]   fxu_op,
  output logic [DATA_W-1:0] fxu_val0,
  output logic [DATA_W-1:0] fxu_val1,
  input  logic              fxu_busy
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]             ent_free, ent_ready, ent_alloc, ent_issue;
  logic [NUM_ENTRIES-1:0][OP_W-1:0]   ent_op;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0] ent_val0, ent_val1;
  logic [IDX_W-1:0]                   alloc_idx, issue_idx;
  logic                               issue_go;

  // Lowest-index priority: scan downward so the last hit wins.
  always_comb begin
    alloc_idx = '0;
    issue_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_free[i])  alloc_idx = IDX_W'(i);
      if (ent_ready[i]) issue_idx = IDX_W'(i);
    end
  end

  assign full     = ~|ent_free;
  assign disp_tag = BASE_TAG + TAG_W'(alloc_idx);

  // FXU occupies two cycles per op: no issue right after an issue, and none
  // while it reports busy outside our own issue pulse.
  assign issue_go = !fxu_valid && !(fxu_busy && !fxu_valid) && |ent_ready;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
    assign ent_alloc[i] = disp_valid && !full && (alloc_idx == IDX_W'(i));
    assign ent_issue[i] = issue_go && (issue_idx == IDX_W'(i));

    fxu_rs_entry #(.TAG(BASE_TAG + TAG_W'(i))) u_ent (
      .clk       (clk),
      .reset     (reset),
      .alloc     (ent_alloc[i]),
      .issue     (ent_issue[i]),
      .disp_op   (disp_op),
      .disp_rdy0 (disp_rdy0),
      .disp_tag0 (disp_tag0),
      .disp_val0 (disp_val0),
      .disp_rdy1 (disp_rdy1),
      .disp_tag1 (disp_tag1),
      .disp_val1 (disp_val1),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .is_free   (ent_free[i]),
      .is_ready  (ent_ready[i]),
      .op        (ent_op[i]),
      .val0      (ent_val0[i]),
      .val1      (ent_val1[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fxu_valid  <= 1'b0;
      fxu_rs_num <= '0;
      fxu_op     <= '0;
      fxu_val0   <= '0;
      fxu_val1   <= '0;
    end else begin
      fxu_valid <= issue_go;
      if (issue_go) begin
        fxu_rs_num <= BASE_TAG + TAG_W'(issue_idx);
        fxu_op     <= ent_op[issue_idx];
        fxu_val0   <= ent_val0[issue_idx];
        fxu_val1   <= ent_val1[issue_idx];
      end
    end
  end
endmodule

// File: tb/tb_fxu_rs.sv
module tb_fxu_rs;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_valid, disp_rdy0, disp_rdy1;
  logic [3:0]  disp_op;
  logic [5:0]  disp_tag0, disp_tag1, disp_tag;
  logic [15:0] disp_val0, disp_val1;
  logic        full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        fxu_valid, fxu_busy;
  logic [5:0]  fxu_rs_num;
  logic [3:0]  fxu_op;
  logic [15:0] fxu_val0, fxu_val1;

  int n_tests = 0;
  int n_fail  = 0;

  fxu_rs dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_rdy0(disp_rdy0), .disp_tag0(disp_tag0), .disp_val0(disp_val0),
    .disp_rdy1(disp_rdy1), .disp_tag1(disp_tag1), .disp_val1(disp_val1),
    .disp_tag(disp_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fxu_valid(fxu_valid), .fxu_rs_num(fxu_rs_num), .fxu_op(fxu_op),
    .fxu_val0(fxu_val0), .fxu_val1(fxu_val1), .fxu_busy(fxu_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  // Reference model: each slot is free / waiting / ready / in the FXU.
  // 0=free 1=waiting 2=ready 3=in FXU
  int          m_st [N];
  bit          m_h0 [N], m_h1 [N];
  logic [5:0]  m_t0 [N], m_t1 [N];
  logic [15:0] m_v0 [N], m_v1 [N];
  logic [3:0]  m_op [N];
  bit          m_fv;
  logic [5:0]  m_num;
  logic [3:0]  m_fop;
  logic [15:0] m_f0, m_f1;

  always @(posedge clk) begin : model
    int a, s;
    bit go;
    if (reset) begin
      for (int i = 0; i < N; i++) m_st[i] = 0;
      m_fv = 0; m_num = 0; m_fop = 0; m_f0 = 0; m_f1 = 0;
    end else begin
      a = -1; s = -1;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == 0 && a < 0) a = i;
        if (m_st[i] == 2 && s < 0) s = i;
      end
      go = !m_fv && !fxu_busy && (s >= 0);
      if (go) begin
        m_num = 6'(s); m_fop = m_op[s]; m_f0 = m_v0[s]; m_f1 = m_v1[s];
      end
      m_fv = go;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == 0) begin
          if (disp_valid && i == a) begin
            m_op[i] = disp_op; m_t0[i] = disp_tag0; m_t1[i] = disp_tag1;
            m_h0[i] = disp_rdy0 || (cdb_valid && cdb_tag == disp_tag0);
            m_h1[i] = disp_rdy1 || (cdb_valid && cdb_tag == disp_tag1);
            m_v0[i] = disp_rdy0 ? disp_val0 : cdb_data;
            m_v1[i] = disp_rdy1 ? disp_val1 : cdb_data;
            m_st[i] = (m_h0[i] && m_h1[i]) ? 2 : 1;
          end
        end else if (m_st[i] == 1) begin
          if (!m_h0[i] && cdb_valid && cdb_tag == m_t0[i]) begin m_h0[i] = 1; m_v0[i] = cdb_data; end
          if (!m_h1[i] && cdb_valid && cdb_tag == m_t1[i]) begin m_h1[i] = 1; m_v1[i] = cdb_data; end
          if (m_h0[i] && m_h1[i]) m_st[i] = 2;
        end else if (m_st[i] == 2) begin
          if (go && i == s) m_st[i] = 3;
        end else begin
          if (cdb_valid && cdb_tag == 6'(i)) m_st[i] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    disp_valid = 0; disp_op = 0; disp_rdy0 = 0; disp_tag0 = 0; disp_val0 = 0;
    disp_rdy1 = 0; disp_tag1 = 0; disp_val1 = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic disp(input logic [3:0] op, input logic r0, input logic [5:0] t0,
                      input logic [15:0] v0, input logic r1, input logic [5:0] t1,
                      input logic [15:0] v1);
    disp_valid = 1; disp_op = op;
    disp_rdy0 = r0; disp_tag0 = t0; disp_val0 = v0;
    disp_rdy1 = r1; disp_tag1 = t1; disp_val1 = v1;
  endtask

  task automatic bcast(input logic [5:0] t, input logic [15:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    @(negedge clk);
    n_tests++; if (fxu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fxu_valid); end
    n_tests++; if ({fxu_rs_num, fxu_op, fxu_val0, fxu_val1} !== 42'd0) begin n_fail++;
      $display("FAIL reset_payload: got num=%0d op=%0d v0=%h v1=%h want all 0", fxu_rs_num, fxu_op, fxu_val0, fxu_val1); end
    n_tests++; if (full !== 1'b0 || disp_tag !== 6'd0) begin n_fail++;
      $display("FAIL reset_alloc: got full=%b tag=%0d want full=0 tag=0", full, disp_tag); end
    tick();
  endtask

  task automatic test_basic();
    disp(4'd1, 1, 0, 16'd3, 1, 0, 16'd4);
    @(negedge clk);
    n_tests++; if (disp_tag !== 6'd0) begin n_fail++; $display("FAIL basic_tag: got %0d want 0", disp_tag); end
    tick(); idle();
    @(negedge clk);
    n_tests++; if (fxu_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b want 0", fxu_valid); end
    tick();
    @(negedge clk);
    n_tests++; if ({fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1} !== {1'b1, 6'd0, 4'd1, 16'd3, 16'd4}) begin n_fail++;
      $display("FAIL basic_issue: got v=%b num=%0d op=%0d v0=%0d v1=%0d want 1 0 1 3 4", fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1); end
    tick();
    @(negedge clk);
    n_tests++; if (fxu_valid !== 1'b0 || disp_tag !== 6'd1) begin n_fail++;
      $display("FAIL basic_held: got v=%b tag=%0d want v=0 tag=1", fxu_valid, disp_tag); end
    bcast(0, 0); tick(); idle();
    @(negedge clk);
    n_tests++; if (disp_tag !== 6'd0) begin n_fail++; $display("FAIL basic_freed: got tag %0d want 0", disp_tag); end
  endtask

  task automatic test_capture();
    disp(4'd6, 0, 6'd9, 16'd0, 1, 0, 16'd7);
    tick(); idle(); tick();
    bcast(6'd9, 16'd7); tick(); idle();
    @(negedge clk);
    n_tests++; if (fxu_valid !== 1'b0) begin n_fail++; $display("FAIL capture_early: got %b want 0", fxu_valid); end
    tick();
    @(negedge clk);
    n_tests++; if ({fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1} !== {1'b1, 6'd0, 4'd6, 16'd7, 16'd7}) begin n_fail++;
      $display("FAIL capture_issue: got v=%b num=%0d op=%0d v0=%0d v1=%0d want 1 0 6 7 7", fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1); end
    tick(); bcast(0, 0); tick(); idle();
  endtask

  task automatic test_bypass();
    disp(4'd1, 0, 6'd5, 16'd0, 1, 0, 16'd1);
    bcast(6'd5, 16'h1234);
    tick(); idle(); tick();
    @(negedge clk);
    n_tests++; if ({fxu_valid, fxu_val0, fxu_val1} !== {1'b1, 16'h1234, 16'd1}) begin n_fail++;
      $display("FAIL bypass_issue: got v=%b v0=%h v1=%h want 1 1234 0001", fxu_valid, fxu_val0, fxu_val1); end
    tick(); bcast(0, 0); tick(); idle();
  endtask

  task automatic test_full();
    logic [5:0] q[$];
    bit prev = 0;
    for (int k = 0; k < 14; k++) begin
      if (k < 4)       disp(4'd1, 1, 0, 16'(10 + k), 1, 0, 16'(20 + k));
      else if (k == 4) disp(4'd1, 1, 0, 16'd99, 1, 0, 16'd99);
      else             idle();
      @(negedge clk);
      if (k == 4) begin
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", full); end
      end
      if (fxu_valid) begin
        n_tests++; if (prev) begin n_fail++; $display("FAIL full_pacing: issue at k=%0d right after previous issue", k); end
        n_tests++; if (fxu_val0 !== 16'(10 + fxu_rs_num) || fxu_val1 !== 16'(20 + fxu_rs_num)) begin n_fail++;
          $display("FAIL full_payload: num=%0d got v0=%0d v1=%0d want %0d %0d", fxu_rs_num, fxu_val0, fxu_val1, 10 + fxu_rs_num, 20 + fxu_rs_num); end
        q.push_back(fxu_rs_num);
      end
      prev = fxu_valid;
      tick();
    end
    n_tests++; if (q.size() != 4 || q[0] !== 6'd0 || q[1] !== 6'd1 || q[2] !== 6'd2 || q[3] !== 6'd3) begin n_fail++;
      $display("FAIL full_order: got %0d issues %p want 0,1,2,3", q.size(), q); end
    bcast(1, 0);
    @(negedge clk);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_same_cycle: got %b want 1", full); end
    tick(); idle();
    @(negedge clk);
    n_tests++; if (full !== 1'b0 || disp_tag !== 6'd1) begin n_fail++;
      $display("FAIL full_release: got full=%b tag=%0d want 0 1", full, disp_tag); end
    bcast(0, 0); tick(); bcast(2, 0); tick(); bcast(3, 0); tick(); idle(); tick();
  endtask

  task automatic test_busy();
    fxu_busy = 1;
    disp(4'd1, 1, 0, 16'd5, 1, 0, 16'd6);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (fxu_valid !== 1'b0) begin n_fail++; $display("FAIL busy_hold%0d: got %b want 0", k, fxu_valid); end
      tick();
    end
    fxu_busy = 0;
    @(negedge clk);
    n_tests++; if (fxu_valid !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b want 0", fxu_valid); end
    tick();
    @(negedge clk);
    n_tests++; if (fxu_valid !== 1'b1 || fxu_val0 !== 16'd5) begin n_fail++;
      $display("FAIL busy_issue: got v=%b v0=%0d want 1 5", fxu_valid, fxu_val0); end
    tick(); bcast(0, 0); tick(); idle();
  endtask

  task automatic test_reset_mid();
    disp(4'd1, 1, 0, 16'd1, 1, 0, 16'd2); tick();
    disp(4'd1, 0, 6'd20, 16'd0, 1, 0, 16'd3); tick();
    idle(); tick();
    reset = 1; tick(); reset = 0;
    @(negedge clk);
    n_tests++; if (fxu_valid !== 1'b0 || full !== 1'b0 || disp_tag !== 6'd0) begin n_fail++;
      $display("FAIL midreset_state: got v=%b full=%b tag=%0d want 0 0 0", fxu_valid, full, disp_tag); end
    for (int k = 0; k < 4; k++) begin
      if (k == 0) bcast(0, 0); else if (k == 1) bcast(1, 0); else if (k == 2) bcast(6'd20, 16'd8); else idle();
      tick();
      @(negedge clk);
      n_tests++; if (fxu_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale%0d: got %b want 0", k, fxu_valid); end
    end
    idle(); tick();
  endtask

  task automatic test_random();
    int busyq[$];
    bit exp_full;
    logic [5:0] exp_tag;
    for (int c = 0; c < 500; c++) begin
      idle();
      if ($urandom_range(1, 0) == 1)
        disp(($urandom_range(1, 0) == 1) ? 4'd1 : 4'd6,
             $urandom_range(2, 0) != 0, 6'(8 + $urandom_range(5, 0)), 16'($urandom),
             $urandom_range(2, 0) != 0, 6'(8 + $urandom_range(5, 0)), 16'($urandom));
      busyq.delete();
      for (int i = 0; i < N; i++) if (m_st[i] == 3) busyq.push_back(i);
      if ($urandom_range(9, 0) < 6) begin
        if (busyq.size() > 0 && $urandom_range(1, 0) == 1)
          bcast(6'(busyq[$urandom_range(busyq.size() - 1, 0)]), 16'($urandom));
        else
          bcast(6'(8 + $urandom_range(5, 0)), 16'($urandom));
      end
      fxu_busy = ($urandom_range(9, 0) < 3);
      exp_full = 1; exp_tag = 0;
      for (int i = N - 1; i >= 0; i--) if (m_st[i] == 0) begin exp_full = 0; exp_tag = 6'(i); end
      @(negedge clk);
      n_tests++; if (full !== exp_full || (!exp_full && disp_tag !== exp_tag)) begin n_fail++;
        $display("FAIL rand_alloc c=%0d: got full=%b tag=%0d want full=%b tag=%0d", c, full, disp_tag, exp_full, exp_tag); end
      n_tests++; if ({fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1} !== {m_fv, m_num, m_fop, m_f0, m_f1}) begin n_fail++;
        $display("FAIL rand_issue c=%0d: got v=%b num=%0d op=%0d v0=%h v1=%h want v=%b num=%0d op=%0d v0=%h v1=%h",
                 c, fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1, m_fv, m_num, m_fop, m_f0, m_f1); end
      tick();
    end
    idle(); fxu_busy = 0;
  endtask

  initial begin
    reset = 1; fxu_busy = 0; idle();
    test_reset();
    test_basic();
    test_capture();
    test_bypass();
    test_full();
    test_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fxu_rs.md
Name: fxu_rs

Overview:
- Reservation-station bank that sits in front of the fixed-point unit in the Tomasulo core.
- Accepts dispatched ADD/JEQ micro-ops with operands that are either present or tagged. Snoops the common data bus (CDB) to capture pending operands.
- Issues ready entries to the FXU as valid/rs_num/op/val0/val1, pacing issues against the FXU's two-cycle occupancy.
- An entry's tag stays reserved until the FXU result carrying that tag appears on the CDB, so tags are never aliased.

Parameters:
- NUM_ENTRIES, 4, number of station entries (2..8).
- BASE_TAG, 6'd0, tag of entry 0; entry i owns tag BASE_TAG+i.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- disp_valid  in  1  dispatch request this cycle.
- disp_op  in  4  opcode (ADD=1, JEQ=6).
- disp_rdy0  in  1  operand 0 is present in disp_val0.
- disp_tag0  in  6  producer tag for operand 0 when not present.
- disp_val0  in  16  operand 0 value.
- disp_rdy1, disp_tag1, disp_val1  in  1/6/16  same for operand 1.
- disp_tag  out  6  tag the accepted dispatch receives (combinational, valid when !full).
- full  out  1  no free entry; dispatch ignored.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  6  broadcasting tag.
- cdb_data  in  16  broadcast value.
- fxu_valid  out  1  issue strobe to FXU (registered).
- fxu_rs_num  out  6  tag of issued entry.
- fxu_op  out  4  issued opcode.
- fxu_val0, fxu_val1  out  16  issued operands.
- fxu_busy  in  1  FXU busy indication.

Behaviour:
- Entry states: FREE -> WAIT (an operand is pending) or READY (both present) -> ISSUED -> FREE.
  - WAIT -> READY when the last pending operand's tag matches cdb_tag with cdb_valid.
  - READY -> ISSUED when selected for issue.
  - ISSUED -> FREE when cdb_valid and cdb_tag == own tag.
  - A WAIT/READY entry whose own tag is broadcast is an error: $display and $finish.
- Dispatch:
  - Allocates the lowest-index FREE entry. disp_tag = BASE_TAG + that index.
  - full = no FREE entry, evaluated on the pre-clock state.
  - An entry freed this cycle is usable next cycle, not this cycle.
- Dispatch/CDB bypass: if a dispatched operand is not present and its tag equals cdb_tag while cdb_valid is high in the same cycle, the entry captures cdb_data and marks that operand present.
- Operand capture: every non-present operand in WAIT entries compares its tag with cdb_tag each cycle. On a match it latches cdb_data. Both operands may match the same broadcast.
- Issue selection: the lowest-index READY entry. An entry that became READY this cycle is eligible next cycle.
- Issue pacing:
  - fxu_valid is a one-cycle registered pulse.
  - It may be set for cycle t+1 only if fxu_valid == 0 at t and !(fxu_busy && !fxu_valid) at t.
  - This gives at most one issue every 2 cycles, matching the FXU's capture/compute occupancy.
- Issue outputs: fxu_rs_num/op/val0/val1 are registered alongside fxu_valid. They hold their last values when fxu_valid == 0.
- Latency: dispatch with both operands present at cycle t -> fxu_valid at t+2 at the earliest (READY at t+1, registered issue).
- Reset values:
  - All entries FREE; fxu_valid=0; fxu_rs_num=0; fxu_op=0; fxu_val0=fxu_val1=0.
  - full=0; disp_tag=BASE_TAG.
- Reset mid-operation discards all entries, including ISSUED ones. Later CDB broadcasts of those tags free nothing and do not trigger the error check.
- Tags outside [BASE_TAG, BASE_TAG+NUM_ENTRIES) on the CDB only affect operand capture.

Decomposition:
- Shared package holds:
  - opcode constants ADD=1, JEQ=6;
  - tag width 6 and data width 16;
  - entry-state encodings FREE/WAIT/READY/ISSUED.
- One sub-module is natural: fxu_rs_entry, covering one entry's state, operand capture and free-on-broadcast logic, instantiated NUM_ENTRIES times.
- Allocation, issue selection and pacing stay in fxu_rs.

Test Plan:
- After reset, dispatch ADD with both operands present (3, 4) -> disp_tag=0. fxu_valid pulses 2 cycles later with rs_num=0, op=1, val0=3, val1=4. Entry stays ISSUED until cdb_tag=0.
- Dispatch JEQ with operand 0 pending on tag 9, operand 1 = 7; two cycles later CDB broadcasts tag 9, data 7 -> fxu_valid 2 cycles after the broadcast with val0=7, val1=7, op=6.
- Same-cycle bypass: dispatch with disp_tag0=5 pending while cdb_valid, cdb_tag=5, cdb_data=0x1234 -> issued fxu_val0=0x1234.
- Fill all 4 entries with ready ADDs -> full=1 and a fifth dispatch is ignored. Issues occur on alternate cycles in order of rs_num 0, 1, 2, 3. Broadcasting tag 1 -> full drops next cycle and the next dispatch gets disp_tag=1.
- Hold fxu_busy=1 with fxu_valid=0 for 3 cycles while an entry is READY -> no issue. Issue occurs in the cycle after fxu_busy falls.
- Assert reset while entries are WAIT and ISSUED -> all FREE, fxu_valid=0 next cycle. A subsequent CDB broadcast of an old tag causes no issue and no $finish.
